// File: rtl/pipe_ir_skid.sv
// pipe_ir_skid: IF/ID pipeline register with one-entry skid buffer, flush and bubble counter
//   clk, clr (sync active-high reset)
//   pc4/ins/in_valid/in_ready : fetch-side handshake (in_ready registered, = ~skid_valid)
//   out_valid/dpc4/inst/out_ready : decode-side handshake from the main register
//   flush : kills held and incoming entries; bubble_cnt : saturating count of empty cycles
module pipe_ir_skid #(
  parameter int PC_W = 32,
  parameter int INS_W = 32,
  parameter logic [INS_W-1:0] NOP_INS = '0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [PC_W-1:0]  pc4,
  input  logic [INS_W-1:0] ins,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [PC_W-1:0]  dpc4,
  output logic [INS_W-1:0] inst,
  output logic [CNT_W-1:0] bubble_cnt
);
  logic             skid_valid;
  logic [PC_W-1:0]  skid_pc;
  logic [INS_W-1:0] skid_ins;
  logic             acc;
  logic             con;
  assign in_ready = ~skid_valid;
  always_comb begin
    acc = in_valid & ~skid_valid & ~flush & ~clr;
    con = out_valid & out_ready;
  end
  // Branch order encodes FULL, ONE-stalled-with-accept, load-main, drain-to-empty.
  always_ff @(posedge clk) begin
    if (clr || flush) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
      dpc4 <= '0;
      inst <= NOP_INS;
    end else if (skid_valid) begin
      if (con) begin
        dpc4 <= skid_pc;
        inst <= skid_ins;
        skid_valid <= 1'b0;
      end
    end else if (acc && out_valid && !con) begin
      skid_valid <= 1'b1;
      skid_pc <= pc4;
      skid_ins <= ins;
    end else if (acc) begin
      out_valid <= 1'b1;
      dpc4 <= pc4;
      inst <= ins;
    end else if (con) begin
      out_valid <= 1'b0;
      dpc4 <= '0;
      inst <= NOP_INS;
    end
  end
  always_ff @(posedge clk) begin
    if (clr) bubble_cnt <= '0;
    else if (!out_valid && bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_pipe_ir_skid.sv
// tb_pipe_ir_skid: directed and random checks of pipe_ir_skid against a queue model
module tb_pipe_ir_skid;
  localparam logic [31:0] NOP4 = 32'hDEAD0013;
  logic clk = 1'b0;
  logic clr = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] pc4 = '0, ins = '0;
  logic in_ready, out_valid, in_ready4, out_valid4;
  logic [31:0] dpc4, inst, dpc44, inst4;
  logic [15:0] bubble_cnt;
  logic [3:0] bubble4;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] q[$];
  int cnt = 0, cnt4 = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  pipe_ir_skid dut (
    .clk(clk), .clr(clr), .pc4(pc4), .ins(ins), .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .flush(flush), .out_valid(out_valid), .dpc4(dpc4), .inst(inst),
    .bubble_cnt(bubble_cnt)
  );
  pipe_ir_skid #(.CNT_W(4), .NOP_INS(NOP4)) dut4 (
    .clk(clk), .clr(clr), .pc4(pc4), .ins(ins), .in_valid(in_valid), .in_ready(in_ready4),
    .out_ready(out_ready), .flush(flush), .out_valid(out_valid4), .dpc4(dpc44), .inst(inst4),
    .bubble_cnt(bubble4)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic c, input logic f, input logic v, input logic r,
                      input logic [31:0] p, input logic [31:0] i);
    bit acc;
    @(negedge clk);
    if (chk_en) begin
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("in_ready", 64'(in_ready), 64'(q.size() < 2));
      check("dpc4", 64'(dpc4), q.size() > 0 ? 64'(q[0][63:32]) : 64'd0);
      check("inst", 64'(inst), q.size() > 0 ? 64'(q[0][31:0]) : 64'd0);
      check("bubble_cnt", 64'(bubble_cnt), 64'(cnt));
      check("inst_nop4", 64'(inst4), q.size() > 0 ? 64'(q[0][31:0]) : 64'(NOP4));
      check("bubble_cnt4", 64'(bubble4), 64'(cnt4));
    end
    clr = c; flush = f; in_valid = v; out_ready = r; pc4 = p; ins = i;
    @(posedge clk);
    if (c) begin
      q.delete();
      cnt = 0;
      cnt4 = 0;
    end else begin
      if (q.size() == 0) begin
        cnt = (cnt == 65535) ? cnt : cnt + 1;
        cnt4 = (cnt4 == 15) ? cnt4 : cnt4 + 1;
      end
      if (f) q.delete();
      else begin
        acc = v && q.size() < 2;
        if (r && q.size() > 0) void'(q.pop_front());
        if (acc) q.push_back({p, i});
      end
    end
    chk_en = 1;
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 4, 32'hA);
    step(0, 0, 1, 1, 8, 32'hB);
    step(0, 0, 1, 1, 12, 32'hC);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 4, 32'hA);
    step(0, 0, 1, 0, 8, 32'hB);
    step(0, 0, 1, 0, 12, 32'hC);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 4, 32'hA);
    step(0, 0, 1, 0, 8, 32'hB);
    step(0, 1, 1, 0, 12, 32'hC);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 4, 32'hA);
    step(0, 0, 1, 0, 8, 32'hB);
    step(1, 1, 1, 1, 12, 32'hC);
    step(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, $urandom, $urandom);
    step(0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
